// File: rtl/lcd_controller.sv
// HD44780 character LCD sequencer: power-up wait, fixed init, then byte writes.
// Define LCD_4BIT_EN for a 4-bit bus (high nibble then low nibble on DATA[7:4]).
module lcd_controller #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_E_HIGH  = 24,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_CMD     = 2500,
  parameter int unsigned T_CLEAR   = 82000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        reqValid,
  input  logic        reqRs,
  input  logic [7:0]  reqData,
  output logic        reqReady,
  output logic        initDone,
  output logic [10:0] lcdPins
);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_EHIGH = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;
  localparam logic [2:0] S_IDLE  = 3'd6;

`ifdef LCD_4BIT_EN
  localparam int unsigned N_INIT = 8;
`else
  localparam int unsigned N_INIT = 6;
`endif

  localparam logic [2:0] IDX_LAST = 3'(N_INIT - 1);

  localparam logic [CNT_W-1:0] L_PWR = CNT_W'(T_POWERUP - 1);
  localparam logic [CNT_W-1:0] L_SET = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_EH  = CNT_W'(T_E_HIGH - 1);
  localparam logic [CNT_W-1:0] L_HLD = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_CMD = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] L_CLR = CNT_W'(T_CLEAR - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim;
  logic [2:0]       idx_q, idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       byte_q, byte_d;
  logic             done_q, done_d;
  logic             last;
  logic             is_clr;
  logic [7:0]       data_out;

`ifdef LCD_4BIT_EN
  logic lo_q, lo_d;
  logic half_q, half_d;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h20;
      3'd4:             init_byte = 8'h28;
      3'd5:             init_byte = 8'h0C;
      3'd6:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  assign data_out = lo_q ? {byte_q[3:0], 4'h0}
                         : {byte_q[7:4], 4'h0};
`else
  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  assign data_out = byte_q;
`endif

  // clear and return-home are the only slow commands
  assign is_clr = !rs_q && (byte_q[7:2] == 6'd0)
                  && (byte_q != 8'd0);

  // length of the current phase, minus one
  always_comb begin
    lim = '0;
    case (state_q)
      S_PWRUP: lim = L_PWR;
      S_SETUP: lim = L_SET;
      S_EHIGH: lim = L_EH;
      S_HOLD:  lim = L_HLD;
      S_EXEC:  lim = is_clr ? L_CLR : L_CMD;
      default: lim = '0;
    endcase
  end

  assign last = (cnt_q == lim);

  // sequencing and next-state selection
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    rs_d    = rs_q;
    byte_d  = byte_q;
    done_d  = done_q;
`ifdef LCD_4BIT_EN
    lo_d    = lo_q;
    half_d  = half_q;
`endif
    case (state_q)
      S_PWRUP: begin
        if (last) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        state_d = S_SETUP;
        rs_d    = 1'b0;
        byte_d  = init_byte(idx_q);
`ifdef LCD_4BIT_EN
        lo_d    = 1'b0;
        half_d  = (idx_q < 3'd4);
`endif
      end
      S_SETUP: if (last) state_d = S_EHIGH;
      S_EHIGH: if (last) state_d = S_HOLD;
      S_HOLD: begin
        if (last) begin
`ifdef LCD_4BIT_EN
          // data setup is referenced to E falling,
          // so the low nibble may change as E rises
          if (!lo_q && !half_q) begin
            lo_d    = 1'b1;
            state_d = S_EHIGH;
          end else begin
            state_d = S_EXEC;
          end
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        if (last) begin
          if (done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_INIT;
          end
        end
      end
      S_IDLE: begin
        if (reqValid) begin
          rs_d    = reqRs;
          byte_d  = reqData;
          state_d = S_SETUP;
`ifdef LCD_4BIT_EN
          lo_d    = 1'b0;
          half_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      rs_q    <= 1'b0;
      byte_q  <= 8'd0;
      done_q  <= 1'b0;
`ifdef LCD_4BIT_EN
      lo_q    <= 1'b0;
      half_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rs_q    <= rs_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
`ifdef LCD_4BIT_EN
      lo_q    <= lo_d;
      half_q  <= half_d;
`endif
    end
  end

  assign reqReady = (state_q == S_IDLE);
  assign initDone = done_q;
  assign lcdPins  = {rs_q, 1'b0, (state_q == S_EHIGH), data_out};

endmodule
